// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and line levels for the serial transmit path
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/shift_reg_piso.sv
// shift_reg_piso: parallel-in serial-out register, left shift with zero fill
module shift_reg_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_en,
    output logic              msb_out
);

    logic [DATA_W-1:0] sr;

    // load has priority over shift; both are owned by the frame controller
    always_ff @(posedge clk) begin
        if (reset)
            sr <= '0;
        else if (load)
            sr <= load_data;
        else if (shift_en)
            sr <= sr << 1;
    end

    assign msb_out = sr[DATA_W-1];

endmodule

// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl: sequences start, MSB-first data and stop bits onto a registered serial line
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    tx_state_t state, state_next;
    logic [CW-1:0] cyc_cnt;
    logic [BW-1:0] bit_cnt;
    logic handshake, bnd, last_bit, msb_out, shift_en, line_next;

    assign tx_ready  = (state == IDLE) && !reset;
    assign handshake = tx_valid && tx_ready;
    assign bnd       = cyc_cnt == CW'(CLKS_PER_BIT - 1);
    assign last_bit  = bit_cnt == BW'(DATA_W - 1);
    // The register shifts at the start-bit boundary too, so it runs one bit
    // ahead of the line and msb_out is already the next bit at each boundary.
    assign shift_en  = bnd && (state == START || state == DATA);

    shift_reg_piso #(.DATA_W(DATA_W)) u_sr (
        .clk       (clk),
        .reset     (reset),
        .load      (handshake),
        .load_data (tx_data),
        .shift_en  (shift_en),
        .msb_out   (msb_out)
    );

    // next state and next line level; line is registered from the next state so it aligns with state
    always_comb begin
        state_next = (state == IDLE)  ? (handshake ? START : IDLE) :
                     (state == START) ? (bnd ? DATA : START) :
                     (state == DATA)  ? ((bnd && last_bit) ? STOP : DATA) :
                                        (bnd ? IDLE : STOP);
        line_next  = (state_next == START) ? START_BIT :
                     (state_next == DATA)  ? (bnd ? msb_out : serial_out) :
                     (state_next == STOP)  ? STOP_BIT : LINE_IDLE;
    end

    // state, bit timer, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            serial_out <= LINE_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            cyc_cnt    <= (state_next != state || state == IDLE || bnd) ? '0 : cyc_cnt + CW'(1);
            bit_cnt    <= (state_next != state) ? '0 : (state == DATA && bnd) ? bit_cnt + BW'(1) : bit_cnt;
            serial_out <= line_next;
            busy       <= state_next != IDLE;
            done       <= (state == STOP) && bnd;
        end
    end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// tb_serial_tx_ctrl: directed frames with a per-cycle scoreboard on line/busy/done
module tb_serial_tx_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] tx_data = 8'h00, tx_data2 = 8'h00;
    logic tx_valid = 1'b0, tx_valid2 = 1'b0;
    logic tx_ready, serial_out, busy, done;
    logic tx_ready2, serial_out2, busy2, done2;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    serial_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    serial_tx_ctrl #(.DATA_W(8), .CLKS_PER_BIT(1)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .serial_out (serial_out2),
        .busy       (busy2),
        .done       (done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // frame bits listed first-on-line first: start, 8 data MSB first, stop
    task automatic push_frame(input logic [9:0] bits);
        for (int i = 9; i >= 0; i--)
            for (int c = 0; c < 4; c++)
                exp_q.push_back({bits[i], 1'b1, 1'b0});
        exp_q.push_back(3'b101);
    endtask

    task automatic send(input logic [7:0] d, input logic [9:0] bits, output time t_hs);
        @(negedge clk);
        #1;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 200 && !tx_ready; k++) begin
            @(negedge clk);
            #1;
        end
        t_hs = $time;
        if (!tx_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: tx_ready still 0 after 200 cycles, required 1");
        end else begin
            @(posedge clk);
            t_hs = $time;
            push_frame(bits);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && exp_q.size() > 0; k++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: %0d entries pending, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // monitor: every cycle is either an expected frame cycle or must be idle
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frame_line_busy_done", {29'd0, serial_out, busy, done}, {29'd0, e});
            end else
                check("idle_line_busy_done", {29'd0, serial_out, busy, done}, 32'b100);
        end
    end

    initial begin
        time t1, t2;
        logic [9:0] pat;
        tx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("ready_in_reset", tx_ready, 0);
        end
        tx_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        #1;
        check("ready_after_reset", tx_ready, 1);

        send(8'hA5, 10'b0101001011, t1);
        drop_valid();
        wait_idle();

        send(8'h00, 10'b0000000001, t1);
        send(8'hFF, 10'b0111111111, t2);
        drop_valid();
        check("b2b_period", 32'((t2 - t1) / 10), 41);
        wait_idle();

        send(8'h5A, 10'b0010110101, t1);
        drop_valid();
        repeat (13) @(negedge clk);
        #1;
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("ready_mid_reset", tx_ready, 0);
        @(negedge clk);
        #1;
        check("abort_line", serial_out, 1);
        check("abort_busy", busy, 0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        send(8'h3C, 10'b0001111001, t1);
        drop_valid();
        wait_idle();

        send(8'hC3, 10'b0110000111, t1);
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            #1;
            check("ready_while_busy", tx_ready, 0);
            tx_valid = k[0];
            tx_data  = 8'(k * 37);
        end
        drop_valid();
        wait_idle();

        pat = 10'b0100000001;
        @(negedge clk);
        #1;
        check("cpb1_ready", tx_ready2, 1);
        tx_data2  = 8'h80;
        tx_valid2 = 1'b1;
        @(posedge clk);
        #1;
        tx_valid2 = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            check("cpb1_line", serial_out2, (k <= 10) ? pat[10-k] : 1'b1);
            check("cpb1_busy", busy2, (k <= 10) ? 1 : 0);
            check("cpb1_done", done2, (k == 11) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
